// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers up to 15 payload bytes and
// emits header, payload and XOR parity byte-by-byte, honouring router_busy.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic       corrupt,
  input  logic       router_busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       ready,
  output logic [3:0] buf_count,
  output logic       buf_full,
  output logic       tx_done,
  output logic       cfg_err
);

  // Handshake: a byte moves only on a rising edge with pkt_valid=1 and
  // router_busy=0; otherwise pkt_valid/data_out hold for any number of cycles.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] buf_count_q, buf_count_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] parity_q, parity_d;
  logic       corrupt_q, corrupt_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       ready_q, ready_d;
  logic       tx_done_q, tx_done_d;
  logic       cfg_err_q, cfg_err_d;

  logic [7:0] mem_q [16];
  logic       mem_we;
  logic       consume;
  logic       accept;
  logic [7:0] hdr;
  logic [7:0] par_next;

  assign consume  = pkt_valid_q && !router_busy;
  assign accept   = (state_q == S_IDLE) && start && (dest != 2'd3);
  assign hdr      = {2'b00, buf_count_q, dest};
  assign par_next = parity_q ^ mem_q[idx_q];

  always_comb begin
    state_d     = state_q;
    buf_count_d = buf_count_q;
    len_d       = len_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    parity_d    = parity_q;
    corrupt_d   = corrupt_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    ready_d     = ready_q;
    tx_done_d   = 1'b0;
    cfg_err_d   = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_HEADER;
          len_d       = buf_count_q;
          corrupt_d   = corrupt;
          parity_d    = hdr;
          idx_d       = 4'd0;
          pkt_valid_d = 1'b1;
          data_out_d  = hdr;
          ready_d     = 1'b0;
        end else begin
          cfg_err_d = start && (dest == 2'd3);
          if (clr) begin
            buf_count_d = 4'd0;
          end else if (wr_en && (buf_count_q != 4'd15)) begin
            mem_we      = 1'b1;
            buf_count_d = buf_count_q + 4'd1;
          end
        end
      end
      S_HEADER: begin
        if (consume) begin
          if (len_q != 4'd0) begin
            state_d    = S_PAYLOAD;
            data_out_d = mem_q[4'd0];
          end else begin
            state_d    = S_PARITY;
            data_out_d = parity_q ^ {8{corrupt_q}};
          end
        end
      end
      S_PAYLOAD: begin
        if (consume) begin
          parity_d = par_next;
          if (idx_q == len_q - 4'd1) begin
            state_d    = S_PARITY;
            data_out_d = par_next ^ {8{corrupt_q}};
          end else begin
            idx_d      = idx_q + 4'd1;
            data_out_d = mem_q[idx_q + 4'd1];
          end
        end
      end
      S_PARITY: begin
        if (consume) begin
          state_d     = S_GAP;
          pkt_valid_d = 1'b0;
          data_out_d  = 8'h00;
          tx_done_d   = 1'b1;
          buf_count_d = 4'd0;
          gap_d       = 4'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        ready_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_count_q <= 4'd0;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      gap_q       <= 4'd0;
      parity_q    <= 8'h00;
      corrupt_q   <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      ready_q     <= 1'b1;
      tx_done_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_count_q <= buf_count_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      parity_q    <= parity_d;
      corrupt_q   <= corrupt_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      tx_done_q   <= tx_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Payload storage carries no reset; only buf_count qualifies its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[buf_count_q] <= wr_data;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign buf_count = buf_count_q;
  assign buf_full  = (buf_count_q == 4'd15);
  assign tx_done   = tx_done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed framing cases plus random packets checked
// against a queue-based model of header/payload/parity framing.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic       corrupt = 1'b0;
  logic       router_busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       ready;
  logic [3:0] buf_count;
  logic       buf_full;
  logic       tx_done;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .dest(dest), .corrupt(corrupt), .router_busy(router_busy),
    .pkt_valid(pkt_valid), .data_out(data_out), .ready(ready),
    .buf_count(buf_count), .buf_full(buf_full), .tx_done(tx_done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // All drivers start and end just after a rising edge.
  task automatic do_write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (model_q.size() < 15) model_q.push_back(b);
    check_eq("buf_count_after_write", 32'(buf_count), 32'(model_q.size()));
    check_eq("buf_full", 32'(buf_full), 32'(model_q.size() == 15));
  endtask

  task automatic do_clr(input logic with_wr);
    clr = 1'b1;
    wr_en = with_wr;
    wr_data = 8'h5A;
    @(posedge clk); #1;
    clr = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    check_eq("buf_count_after_clr", 32'(buf_count), 32'd0);
  endtask

  // busy_mode: 0 never busy, 1 random busy, 2 stall 3 cycles while 0x11 shown
  task automatic send_pkt(input logic [1:0] d, input logic c, input int busy_mode, input logic wr_noise);
    logic [7:0] hdr;
    logic [7:0] par;
    int vcyc;
    int stalls;
    int forced;
    int n;
    bit done;
    hdr = {2'b00, 4'(model_q.size()), d};
    par = hdr;
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(hdr);
    foreach (model_q[i]) begin
      exp_q.push_back(model_q[i]);
      par = par ^ model_q[i];
    end
    exp_q.push_back(c ? (par ^ 8'hFF) : par);

    check_eq("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    dest = d;
    corrupt = c;
    @(posedge clk); #1;
    start = 1'b0;
    vcyc = 0;
    stalls = 0;
    forced = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      case (busy_mode)
        1: router_busy = ($urandom_range(0, 99) < 30);
        2: begin
          router_busy = (data_out == 8'h11) && (forced < 3);
          if (router_busy) forced++;
        end
        default: router_busy = 1'b0;
      endcase
      wr_en = wr_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("first_valid", 32'(pkt_valid), 32'd1);
        check_eq("header", 32'(data_out), 32'(hdr));
        check_eq("ready_busy_tx", 32'(ready), 32'd0);
      end
      if (tx_done) begin
        done = 1'b1;
        check_eq("valid_low_at_done", 32'(pkt_valid), 32'd0);
      end else begin
        if (pkt_valid) begin
          vcyc++;
          if (router_busy) stalls++;
          else got_q.push_back(data_out);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) check_eq("tx_done_timeout", 32'd0, 32'd1);

    check_eq("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("valid_cycles", 32'(vcyc), 32'(exp_q.size() + stalls));
    if (busy_mode == 2) check_eq("stall_cycles", 32'(stalls), 32'd3);

    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      router_busy = 1'b0;
      @(negedge clk);
      n++;
      if (n == 1) check_eq("tx_done_pulse", 32'(tx_done), 32'd0);
    end
    check_eq("gap_cycles", 32'(n), 32'(GAP));
    check_eq("buf_empty_after_pkt", 32'(buf_count), 32'd0);
    model_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_buf_count", 32'(buf_count), 32'd0);
    check_eq("rst_tx_done", 32'(tx_done), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic ch0
    do_write(8'hAA); do_write(8'h55); do_write(8'hCC);
    send_pkt(2'd0, 1'b0, 0, 1'b0);

    // Stall on ch1
    do_write(8'h11); do_write(8'h22);
    send_pkt(2'd1, 1'b0, 2, 1'b0);

    // Corrupt parity
    do_write(8'hAA); do_write(8'h55); do_write(8'hCC);
    send_pkt(2'd0, 1'b1, 0, 1'b0);

    // Zero length
    send_pkt(2'd0, 1'b0, 0, 1'b0);

    // dest==3 rejected, buffer kept
    do_write(8'h01); do_write(8'h02);
    start = 1'b1;
    dest = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check_eq("cfg_no_valid", 32'(pkt_valid), 32'd0);
    check_eq("cfg_buf_kept", 32'(buf_count), 32'd2);
    check_eq("cfg_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    check_eq("cfg_err_low", 32'(cfg_err), 32'd0);
    send_pkt(2'd2, 1'b0, 0, 1'b0);

    // Clear, and clear beating a simultaneous write
    do_write(8'h77); do_write(8'h88);
    do_clr(1'b0);
    do_write(8'h99);
    do_clr(1'b1);

    // Max length plus an ignored 16th write
    for (int i = 0; i < 15; i++) do_write(8'h31 + 8'(i));
    do_write(8'hEE);
    send_pkt(2'd0, 1'b0, 0, 1'b0);

    // Reset mid-packet
    for (int i = 0; i < 5; i++) do_write(8'(8'h40 + i));
    start = 1'b1;
    dest = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check_eq("pre_rst_valid", 32'(pkt_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 32'(pkt_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    @(posedge clk); #1;
    check_eq("post_rst_ready", 32'(ready), 32'd1);
    check_eq("post_rst_buf", 32'(buf_count), 32'd0);
    do_write(8'hDE); do_write(8'hAD);
    send_pkt(2'd2, 1'b0, 0, 1'b0);

    // Random packets with random stalls and ignored writes during transmit
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(0, 15);
      for (int i = 0; i < len; i++) do_write(8'($urandom_range(0, 255)));
      send_pkt(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
